fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, 32'h0000_0000, instruction word driven into IF/ID on flush or bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 PCSrc  input  2  from Controller: 00 sequential, 01 branch, 10 jump, 11 reserved (treated as 00).
REQ-006 IFflush  input  1  from Controller: squash the IF/ID contents at this edge.
REQ-007 hazard  input  1  from hazard unit: stall; PC and IF/ID hold.
REQ-008 BranchTarget  input  32  branch target computed in ID.
REQ-009 imem_req  output  1  fetch request; imem_addr is valid while it is high.
REQ-010 imem_addr  output  32  fetch address; equals the PC register.
REQ-011 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in this cycle; may arrive in the same cycle as the request.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 IFID_Inst  output  32  registered instruction to ID.
REQ-014 IFID_PC4  output  32  registered PC+4 of IFID_Inst.
REQ-015 IFID_valid  output  1  IFID_Inst is a real fetched instruction, not a bubble.

Function
REQ-016 The FSM SHALL have states FETCH (imem_req=1), HOLD (imem_req=0, fetched word parked in a 1-entry hold buffer) and DRAIN (imem_req=1, address frozen, response to be discarded).
REQ-017 imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-018 In FETCH, ack with hazard=0 and no redirect: IF/ID loads {imem_rdata, PC+4, valid=1}; PC becomes PC+4. With a zero-wait memory this gives a throughput of 1 instruction per cycle.
REQ-019 In FETCH with no ack: IF/ID loads NOP_INST with valid=0 (bubble) unless hazard=1, in which case IF/ID holds.
REQ-020 In FETCH, ack with hazard=1: IF/ID holds; the word and PC+4 go to the hold buffer; PC becomes PC+4; next state HOLD.
REQ-021 In HOLD with hazard=0: IF/ID loads the hold buffer with valid=1; next state FETCH.
REQ-022 Redirect target SHALL be BranchTarget for PCSrc=01, and {IFID_PC4[31:28], IFID_Inst[25:0], 2'b00} for PCSrc=10.
REQ-023 A redirect SHALL take priority over hazard and over any ack in the same cycle. The fetched or held word is discarded.
REQ-024 A redirect in FETCH with ack, or in HOLD, SHALL set PC to the target and go to FETCH.
REQ-025 A redirect in FETCH without ack SHALL store the target in redirect_pc and go to DRAIN.
REQ-026 In DRAIN, on ack: data is discarded and PC is set to redirect_pc, then FETCH. A further redirect while in DRAIN overwrites redirect_pc.
REQ-027 IFflush=1 SHALL load IF/ID with {NOP_INST, 0, valid=0} regardless of hazard. IFflush takes priority over every IF/ID load.
REQ-028 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-029 While rst=1 at an edge: PC=RESET_PC, IFID_Inst=NOP_INST, IFID_PC4=0, IFID_valid=0, hold buffer empty, redirect_pc=0, state FETCH.
REQ-030 imem_req SHALL be 0 in every cycle in which rst=1.
REQ-031 An ack arriving during reset SHALL be ignored. Reset mid-DRAIN or mid-HOLD abandons all pending data.

Structure
REQ-032 A shared package mips_pkg SHALL hold the PCSrc encodings (PC_SEQ, PC_BR, PC_J), the fetch FSM state enum and the default NOP constant.
REQ-033 The IF/ID register with stall and flush SHALL be a sub-module if_id_reg. The PC, FSM, hold buffer and next-PC mux stay in fetch_stage.

Verification
REQ-034 Reset, then zero-wait memory returning addr+32'h100: IFID_Inst sequence 0x100, 0x104, 0x108 with IFID_PC4 4, 8, 12; one instruction per cycle.
REQ-035 hazard=1 for 2 cycles while an ack arrives at PC=8: IF/ID holds its previous word; then word 0x108 appears with IFID_PC4=12; no word lost or duplicated.
REQ-036 PCSrc=01, BranchTarget=0x40, IFflush=1 at the same edge as an ack: IF/ID is a bubble (valid=0); the next imem_addr is 0x40.
REQ-037 3-cycle memory latency; PCSrc=10 with IFID_Inst=0x0800_0010, IFID_PC4=0x1000_0004 during the wait: addr is held until ack, the response is dropped, then imem_addr=0x1000_0040.
REQ-038 rst asserted in DRAIN with an ack in the same cycle: next cycle PC=RESET_PC, IFID_valid=0, state FETCH.
REQ-039 PC=32'hFFFF_FFFC with an ack: IFID_PC4=0 and the next imem_addr=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: PC source encodings, fetch FSM states and the default NOP word
package mips_pkg;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR = 2'b01;
  localparam logic [1:0] PC_J = 2'b10;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory request/response bus
interface fetch_stage_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, otherwise hold
module if_id_reg import mips_pkg::*; #(
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  input  logic        valid_in,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);
  logic [31:0] inst_q, inst_d, pc4_q, pc4_d;
  logic valid_q, valid_d;
  always_comb begin
    inst_d = flush ? NOP_INST : load ? inst_in : inst_q;
    pc4_d = flush ? '0 : load ? pc4_in : pc4_q;
    valid_d = flush ? 1'b0 : load ? valid_in : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= NOP_INST;
      pc4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign inst = inst_q;
  assign pc4 = pc4_q;
  assign valid = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM, hold buffer and next-PC mux feeding the IF/ID register
module fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    PCSrc,
  input  logic          IFflush,
  input  logic          hazard,
  input  logic [31:0]   BranchTarget,
  fetch_stage_if.master imem,
  output logic [31:0]   IFID_Inst,
  output logic [31:0]   IFID_PC4,
  output logic          IFID_valid
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, redirect_pc_q, redirect_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d, hold_pc4_q, hold_pc4_d;
  logic [31:0] pc4, target, ifid_inst_in, ifid_pc4_in;
  logic redirect, ack, ifid_load, ifid_valid_in;
  assign pc4 = pc_q + 32'd4;
  assign redirect = PCSrc == PC_BR || PCSrc == PC_J;
  assign target = PCSrc == PC_BR ? BranchTarget : {IFID_PC4[31:28], IFID_Inst[25:0], 2'b00};
  assign ack = imem.imem_ack && state_q != HOLD;
  assign imem.imem_req = !rst && state_q != HOLD;
  assign imem.imem_addr = pc_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redirect_pc_d = redirect_pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc4_d = hold_pc4_q;
    // IF/ID takes a bubble each cycle unless stalled or a real word arrives
    ifid_load = !hazard;
    ifid_inst_in = NOP_INST;
    ifid_pc4_in = '0;
    ifid_valid_in = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (ack) pc_d = target;
          else begin
            redirect_pc_d = target;
            state_d = DRAIN;
          end
        end else if (ack) begin
          pc_d = pc4;
          if (hazard) begin
            hold_inst_d = imem.imem_rdata;
            hold_pc4_d = pc4;
            state_d = HOLD;
          end else begin
            ifid_inst_in = imem.imem_rdata;
            ifid_pc4_in = pc4;
            ifid_valid_in = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d = target;
          state_d = FETCH;
        end else if (!hazard) begin
          ifid_inst_in = hold_inst_q;
          ifid_pc4_in = hold_pc4_q;
          ifid_valid_in = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        redirect_pc_d = redirect ? target : redirect_pc_q;
        if (ack) begin
          pc_d = redirect_pc_d;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      redirect_pc_q <= '0;
      hold_inst_q <= NOP_INST;
      hold_pc4_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc4_q <= hold_pc4_d;
    end
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk(clk),
    .rst(rst),
    .flush(IFflush),
    .load(ifid_load),
    .inst_in(ifid_inst_in),
    .pc4_in(ifid_pc4_in),
    .valid_in(ifid_valid_in),
    .inst(IFID_Inst),
    .pc4(IFID_PC4),
    .valid(IFID_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus fetched-word scoreboard for fetch_stage
module tb_fetch_stage;
  import mips_pkg::*;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } word_t;
  typedef struct {
    logic r;
    logic [1:0] ps;
    logic [31:0] b;
    logic f;
    logic h;
    logic e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, hz = 1'b0;
  logic [1:0] pcsrc = PC_SEQ;
  logic [31:0] bt = '0;
  logic [31:0] ifid_inst, ifid_pc4;
  logic ifid_valid;
  int n_tests = 0, n_fail = 0, lat = 0, cnt = 0;
  logic drop = 1'b0, force_ack = 1'b0, cur_req;
  logic [31:0] cur_addr;
  word_t sb[$];
  vec_t tv[15];
  fetch_stage_if imem();
  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .PCSrc(pcsrc),
    .IFflush(flush),
    .hazard(hz),
    .BranchTarget(bt),
    .imem(imem),
    .IFID_Inst(ifid_inst),
    .IFID_PC4(ifid_pc4),
    .IFID_valid(ifid_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h1000_0000 ? 32'h0800_0010 : a + 32'h100;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [1:0] ps, input logic [31:0] b, input logic f, input logic h);
    logic redir, ack;
    word_t w;
    rst = r;
    pcsrc = ps;
    bt = b;
    flush = f;
    hz = h;
    #1;
    cur_req = imem.imem_req;
    cur_addr = imem.imem_addr;
    if (r) chk("req_in_reset", {31'b0, cur_req}, 32'd0);
    ack = force_ack || (cur_req && cnt >= lat);
    cnt = (cur_req && !ack) ? cnt + 1 : 0;
    imem.imem_ack = ack;
    imem.imem_rdata = ack ? mem(cur_addr) : 32'hDEAD_BEEF;
    redir = ps == PC_BR || ps == PC_J;
    if (r) sb.delete();
    else if (!cur_req && (redir || (f && !h)) && sb.size() > 0) void'(sb.pop_back());
    else if (ack && !redir && !drop && !(f && !h)) begin
      w.inst = mem(cur_addr);
      w.pc4 = cur_addr + 32'd4;
      sb.push_back(w);
    end
    drop = !r && !ack && (drop || (redir && cur_req));
    @(posedge clk);
    #1;
    imem.imem_ack = 1'b0;
    if (!r && !h && !f && ifid_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_word: got %h, expected no new word", ifid_inst);
      end else begin
        w = sb.pop_front();
        chk("sb_inst", ifid_inst, w.inst);
        chk("sb_pc4", ifid_pc4, w.pc4);
      end
    end
  endtask
  initial begin
    imem.imem_ack = 1'b0;
    imem.imem_rdata = '0;
    tv[0]  = '{'1, PC_SEQ, '0, '0, '0, '0, 32'h0, '0, NOP, 32'h0};
    tv[1]  = '{'0, PC_SEQ, '0, '0, '0, '1, 32'h0, '1, 32'h100, 32'h4};
    tv[2]  = '{'0, PC_SEQ, '0, '0, '0, '1, 32'h4, '1, 32'h104, 32'h8};
    tv[3]  = '{'0, PC_SEQ, '0, '0, '1, '1, 32'h8, '1, 32'h104, 32'h8};
    tv[4]  = '{'0, PC_SEQ, '0, '0, '1, '0, 32'h0, '1, 32'h104, 32'h8};
    tv[5]  = '{'0, PC_SEQ, '0, '0, '0, '0, 32'h0, '1, 32'h108, 32'hC};
    tv[6]  = '{'0, PC_SEQ, '0, '0, '0, '1, 32'hC, '1, 32'h10C, 32'h10};
    tv[7]  = '{'0, PC_BR, 32'h40, '1, '0, '1, 32'h10, '0, NOP, 32'h0};
    tv[8]  = '{'0, PC_SEQ, '0, '0, '0, '1, 32'h40, '1, 32'h140, 32'h44};
    tv[9]  = '{'0, 2'b11, '0, '0, '0, '1, 32'h44, '1, 32'h144, 32'h48};
    tv[10] = '{'0, PC_J, '0, '0, '0, '1, 32'h48, '0, NOP, 32'h0};
    tv[11] = '{'0, PC_SEQ, '0, '0, '0, '1, 32'h510, '1, 32'h610, 32'h514};
    tv[12] = '{'0, PC_SEQ, '0, '0, '1, '1, 32'h514, '1, 32'h610, 32'h514};
    tv[13] = '{'0, PC_BR, 32'h200, '0, '1, '0, 32'h0, '1, 32'h610, 32'h514};
    tv[14] = '{'0, PC_SEQ, '0, '0, '0, '1, 32'h200, '1, 32'h300, 32'h204};
    for (int i = 0; i < 15; i++) begin
      step(tv[i].r, tv[i].ps, tv[i].b, tv[i].f, tv[i].h);
      chk($sformatf("v%0d_req", i), {31'b0, cur_req}, {31'b0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("v%0d_addr", i), cur_addr, tv[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tv[i].e_valid});
      chk($sformatf("v%0d_inst", i), ifid_inst, tv[i].e_inst);
      if (tv[i].e_valid || tv[i].f) chk($sformatf("v%0d_pc4", i), ifid_pc4, tv[i].e_pc4);
    end
    // jump during a 3-cycle fetch: address frozen, late response dropped
    step('0, PC_BR, 32'h1000_0000, '1, '0);
    step('0, PC_SEQ, '0, '0, '0);
    chk("j_setup_inst", ifid_inst, 32'h0800_0010);
    chk("j_setup_pc4", ifid_pc4, 32'h1000_0004);
    lat = 2;
    step('0, PC_J, '0, '0, '0);
    chk("j_wait1_addr", cur_addr, 32'h1000_0004);
    step('0, PC_SEQ, '0, '0, '0);
    chk("j_wait2_addr", cur_addr, 32'h1000_0004);
    step('0, PC_SEQ, '0, '0, '0);
    chk("j_ack_addr", cur_addr, 32'h1000_0004);
    chk("j_drop_valid", {31'b0, ifid_valid}, 32'd0);
    lat = 0;
    step('0, PC_SEQ, '0, '0, '0);
    chk("j_target_addr", cur_addr, 32'h1000_0040);
    chk("j_target_inst", ifid_inst, 32'h1000_0140);
    // reset while draining, with a response in the same cycle
    lat = 2;
    step('0, PC_BR, 32'h2000_0000, '0, '0);
    force_ack = 1'b1;
    step('1, PC_SEQ, '0, '0, '0);
    force_ack = 1'b0;
    lat = 0;
    chk("rst_drain_valid", {31'b0, ifid_valid}, 32'd0);
    step('0, PC_SEQ, '0, '0, '0);
    chk("rst_drain_req", {31'b0, cur_req}, 32'd1);
    chk("rst_drain_addr", cur_addr, 32'h0);
    chk("rst_drain_inst", ifid_inst, 32'h100);
    // PC wraps past the top of the address space
    step('0, PC_BR, 32'hFFFF_FFFC, '1, '0);
    step('0, PC_SEQ, '0, '0, '0);
    chk("wrap_addr", cur_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    chk("wrap_inst", ifid_inst, 32'h0000_00FC);
    step('0, PC_SEQ, '0, '0, '0);
    chk("wrap_next_addr", cur_addr, 32'h0);
    chk("wrap_next_pc4", ifid_pc4, 32'h4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
